// File: rtl/dmac_ctrl_pkg.sv
// dmac_ctrl_pkg: shared control-bus types and the requester-ID width helper
package dmac_ctrl_pkg;
  localparam int CTRL_ADDR_WIDTH = 32;
  localparam int CTRL_DATA_WIDTH = 32;
  localparam int CTRL_BE_WIDTH = CTRL_DATA_WIDTH / 8;
  typedef struct packed {
    logic [CTRL_ADDR_WIDTH-1:0] add;
    logic                       wen;
    logic [CTRL_DATA_WIDTH-1:0] wdata;
    logic [CTRL_BE_WIDTH-1:0]   be;
  } ctrl_req_t;
  typedef struct packed {
    logic [CTRL_DATA_WIDTH-1:0] rdata;
    logic                       opc;
  } ctrl_rsp_t;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dmac_ctrl_id_fifo.sv
// dmac_ctrl_id_fifo: in-order FIFO of requester IDs awaiting a response
module dmac_ctrl_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/dmac_ctrl_arbiter.sv
// dmac_ctrl_arbiter: round-robin sharing of the DMA control target with in-order response routing
module dmac_ctrl_arbiter
  import dmac_ctrl_pkg::*;
#(
  parameter int NB_REQ = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int ID_WIDTH = id_width(NB_REQ),
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NB_REQ-1:0]                    req_i,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]    add_i,
  input  logic [NB_REQ-1:0]                    wen_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
  input  logic [NB_REQ-1:0][BE_WIDTH-1:0]      be_i,
  output logic [NB_REQ-1:0]                    gnt_o,
  output logic [NB_REQ-1:0]                    r_valid_o,
  output logic [DATA_WIDTH-1:0]                r_rdata_o,
  output logic                                 r_opc_o,
  output logic                                 tgt_req_o,
  output logic [ADDR_WIDTH-1:0]                tgt_add_o,
  output logic                                 tgt_wen_o,
  output logic [DATA_WIDTH-1:0]                tgt_wdata_o,
  output logic [BE_WIDTH-1:0]                  tgt_be_o,
  output logic [ID_WIDTH-1:0]                  tgt_id_o,
  input  logic                                 tgt_gnt_i,
  input  logic                                 tgt_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                tgt_r_rdata_i,
  input  logic                                 tgt_r_opc_i,
  input  logic [ID_WIDTH-1:0]                  tgt_r_id_i,
  output logic [CNT_WIDTH-1:0]                 outstanding_o,
  output logic                                 err_o
);
  logic [ID_WIDTH-1:0] rr_ptr, lock_idx, rr_win, win, head;
  logic lock_vld, full, empty, push, pop;
  function automatic logic [ID_WIDTH-1:0] rr_idx(input logic [ID_WIDTH-1:0] ptr, input int k);
    return ID_WIDTH'((int'(ptr) + k) % NB_REQ);
  endfunction
  always_comb begin
    rr_win = '0;
    for (int k = NB_REQ - 1; k >= 0; k--) rr_win = req_i[rr_idx(rr_ptr, k)] ? rr_idx(rr_ptr, k) : rr_win;
  end
  assign win = (lock_vld && req_i[lock_idx]) ? lock_idx : rr_win;
  assign tgt_req_o = |req_i && !full && !rst_i;
  assign tgt_add_o = add_i[win];
  assign tgt_wen_o = wen_i[win];
  assign tgt_wdata_o = wdata_i[win];
  assign tgt_be_o = be_i[win];
  assign tgt_id_o = win;
  assign push = tgt_req_o && tgt_gnt_i;
  assign pop = tgt_r_valid_i && !empty && !rst_i;
  assign gnt_o = push ? NB_REQ'(1) << win : '0;
  assign r_valid_o = pop ? NB_REQ'(1) << head : '0;
  assign r_rdata_o = tgt_r_rdata_i;
  assign r_opc_o = tgt_r_opc_i;
  dmac_ctrl_id_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(ID_WIDTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push),
    .pop(pop),
    .din(win),
    .full(full),
    .empty(empty),
    .head(head),
    .count(outstanding_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      err_o <= 1'b0;
    end else begin
      lock_vld <= tgt_req_o && !tgt_gnt_i;
      lock_idx <= win;
      if (push) rr_ptr <= (win == ID_WIDTH'(NB_REQ - 1)) ? '0 : win + ID_WIDTH'(1);
      if (tgt_r_valid_i && (empty || tgt_r_id_i != head)) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// tb_dmac_ctrl_arbiter: scenario bench with an expected-ID scoreboard for dmac_ctrl_arbiter
module tb_dmac_ctrl_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] req = '0, wen, gnt, r_valid;
  logic [9:0][31:0] add, wdata;
  logic [9:0][3:0] be;
  logic [31:0] r_rdata, tgt_add, tgt_wdata, tgt_r_rdata = '0;
  logic r_opc, tgt_req, tgt_wen, tgt_gnt = 1'b0, tgt_r_valid = 1'b0, tgt_r_opc = 1'b0, err;
  logic [3:0] tgt_be, tgt_id, tgt_r_id = '0;
  logic [2:0] outstanding;
  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  dmac_ctrl_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_opc_o(r_opc),
    .tgt_req_o(tgt_req), .tgt_add_o(tgt_add), .tgt_wen_o(tgt_wen), .tgt_wdata_o(tgt_wdata),
    .tgt_be_o(tgt_be), .tgt_id_o(tgt_id), .tgt_gnt_i(tgt_gnt), .tgt_r_valid_i(tgt_r_valid),
    .tgt_r_rdata_i(tgt_r_rdata), .tgt_r_opc_i(tgt_r_opc), .tgt_r_id_i(tgt_r_id),
    .outstanding_o(outstanding), .err_o(err)
  );
  task automatic test_reset();
    rst = 1'b1;
    req = '1;
    tgt_gnt = 1'b1;
    tgt_r_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      n_checks++; if (tgt_req !== 1'b0) begin n_fail++; $display("FAIL reset_tgt_req c=%0d got %b want 0", c, tgt_req); end
      n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt c=%0d got %h want 0", c, gnt); end
      n_checks++; if (r_valid !== '0) begin n_fail++; $display("FAIL reset_r_valid c=%0d got %h want 0", c, r_valid); end
    end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    req = '0;
    tgt_gnt = 1'b0;
    tgt_r_valid = 1'b0;
  endtask
  task automatic test_drain();
    int n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      req = '0;
      tgt_gnt = 1'b0;
      tgt_r_valid = 1'b1;
      tgt_r_id = 4'(exp_q[0]);
      tgt_r_opc = n[0];
      tgt_r_rdata = 32'hBEEF_0000 + 32'(n);
      #1;
      n_checks++; if (r_valid !== 10'(1) << exp_q[0]) begin n_fail++; $display("FAIL drain_r_valid got %h want %h", r_valid, 10'(1) << exp_q[0]); end
      n_checks++; if (r_opc !== n[0] || r_rdata !== 32'hBEEF_0000 + 32'(n)) begin n_fail++; $display("FAIL drain_rsp got %b/%h want %b/%h", r_opc, r_rdata, n[0], 32'hBEEF_0000 + 32'(n)); end
      void'(exp_q.pop_front());
      n++;
    end
    @(negedge clk);
    tgt_r_valid = 1'b0;
    #1;
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL drain_outstanding got %0d want 0", outstanding); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL drain_err got %b want 0", err); end
  endtask
  task automatic test_fairness();
    int seen[10];
    int exp_id;
    foreach (seen[i]) seen[i] = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      req = '1;
      tgt_gnt = 1'b1;
      tgt_r_valid = exp_q.size() > 0;
      tgt_r_id = exp_q.size() > 0 ? 4'(exp_q[0]) : 4'd0;
      tgt_r_rdata = 32'hD000_0000 + 32'(c);
      #1;
      exp_id = c % 10;
      n_checks++; if (tgt_req !== 1'b1 || tgt_id !== 4'(exp_id)) begin n_fail++; $display("FAIL fair_id c=%0d got req=%b id=%0d want 1/%0d", c, tgt_req, tgt_id, exp_id); end
      n_checks++; if (gnt !== 10'(1) << exp_id) begin n_fail++; $display("FAIL fair_gnt c=%0d got %h want %h", c, gnt, 10'(1) << exp_id); end
      n_checks++; if (tgt_add !== add[exp_id] || tgt_wdata !== wdata[exp_id] || tgt_be !== be[exp_id] || tgt_wen !== wen[exp_id]) begin n_fail++; $display("FAIL fair_payload c=%0d got %h/%h/%h/%b", c, tgt_add, tgt_wdata, tgt_be, tgt_wen); end
      n_checks++; if (outstanding !== (c == 0 ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL fair_outstanding c=%0d got %0d", c, outstanding); end
      if (exp_q.size() > 0) begin
        n_checks++; if (r_valid !== 10'(1) << exp_q[0] || r_rdata !== tgt_r_rdata) begin n_fail++; $display("FAIL fair_rsp c=%0d got %h/%h want %h", c, r_valid, r_rdata, 10'(1) << exp_q[0]); end
        void'(exp_q.pop_front());
      end else begin
        n_checks++; if (r_valid !== '0) begin n_fail++; $display("FAIL fair_no_rsp c=%0d got %h want 0", c, r_valid); end
      end
      if (c < 10) for (int i = 0; i < 10; i++) seen[i] += int'(gnt[i]);
      exp_q.push_back(exp_id);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (seen[i] != 1) begin n_fail++; $display("FAIL fair_once req=%0d got %0d grants want 1", i, seen[i]); end
    end
    test_drain();
  endtask
  task automatic test_lock();
    logic [9:0] req_seq[9] = '{10'h028, 10'h028, 10'h028, 10'h028, 10'h028, 10'h038, 10'h038, 10'h018, 10'h010};
    logic gnt_seq[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int id_seq[9] = '{3, 3, 3, 3, 5, 5, 5, 3, 4};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req = req_seq[c];
      tgt_gnt = gnt_seq[c];
      #1;
      n_checks++; if (tgt_req !== 1'b1 || tgt_id !== 4'(id_seq[c])) begin n_fail++; $display("FAIL lock_id c=%0d got req=%b id=%0d want 1/%0d", c, tgt_req, tgt_id, id_seq[c]); end
      n_checks++; if (gnt !== (gnt_seq[c] ? 10'(1) << id_seq[c] : 10'd0)) begin n_fail++; $display("FAIL lock_gnt c=%0d got %h", c, gnt); end
      if (gnt_seq[c]) exp_q.push_back(id_seq[c]);
    end
    test_drain();
  endtask
  task automatic test_full();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = '1;
      tgt_gnt = 1'b1;
      #1;
      n_checks++; if (tgt_id !== 4'(6 + c) || gnt !== 10'(1) << (6 + c)) begin n_fail++; $display("FAIL full_fill c=%0d got id=%0d gnt=%h want %0d", c, tgt_id, gnt, 6 + c); end
      n_checks++; if (outstanding !== 3'(c)) begin n_fail++; $display("FAIL full_count c=%0d got %0d want %0d", c, outstanding, c); end
      exp_q.push_back(6 + c);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tgt_r_valid = c == 1;
      tgt_r_id = 4'(exp_q[0]);
      #1;
      n_checks++; if (outstanding !== 3'd4 || tgt_req !== 1'b0 || gnt !== '0) begin n_fail++; $display("FAIL full_stall c=%0d got cnt=%0d req=%b gnt=%h want 4/0/0", c, outstanding, tgt_req, gnt); end
      n_checks++; if (r_valid !== (c == 1 ? 10'(1) << exp_q[0] : 10'd0)) begin n_fail++; $display("FAIL full_rsp c=%0d got %h", c, r_valid); end
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    tgt_r_valid = 1'b0;
    #1;
    n_checks++; if (outstanding !== 3'd3 || tgt_req !== 1'b1 || tgt_id !== 4'd0 || gnt !== 10'd1) begin n_fail++; $display("FAIL full_resume got cnt=%0d req=%b id=%0d gnt=%h want 3/1/0/001", outstanding, tgt_req, tgt_id, gnt); end
    exp_q.push_back(0);
    test_drain();
  endtask
  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = '1;
      tgt_gnt = 1'b1;
      tgt_r_valid = c >= 2;
      tgt_r_id = 4'(exp_q.size() > 0 ? exp_q[0] : 0);
      #1;
      n_checks++; if (tgt_id !== 4'(1 + c) || gnt !== 10'(1) << (1 + c)) begin n_fail++; $display("FAIL b2b_gnt c=%0d got id=%0d want %0d", c, tgt_id, 1 + c); end
      n_checks++; if (outstanding !== (c == 0 ? 3'd0 : c == 1 ? 3'd1 : 3'd2)) begin n_fail++; $display("FAIL b2b_count c=%0d got %0d", c, outstanding); end
      if (c >= 2) begin
        n_checks++; if (r_valid !== 10'(1) << exp_q[0]) begin n_fail++; $display("FAIL b2b_rsp c=%0d got %h want %h", c, r_valid, 10'(1) << exp_q[0]); end
        void'(exp_q.pop_front());
      end
      exp_q.push_back(1 + c);
    end
    @(negedge clk);
    req = '0;
    tgt_r_valid = 1'b0;
    #1;
    n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL b2b_hold got %0d want 2", outstanding); end
    test_drain();
  endtask
  task automatic test_errors();
    @(negedge clk);
    req = '0;
    tgt_r_valid = 1'b1;
    tgt_r_id = 4'd0;
    #1;
    n_checks++; if (r_valid !== '0) begin n_fail++; $display("FAIL err_empty_drop got %h want 0", r_valid); end
    @(negedge clk);
    tgt_r_valid = 1'b0;
    #1;
    n_checks++; if (err !== 1'b1 || outstanding !== 3'd0) begin n_fail++; $display("FAIL err_empty_flag got err=%b cnt=%0d want 1/0", err, outstanding); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", err); end
    req = 10'h080;
    tgt_gnt = 1'b1;
    #1;
    n_checks++; if (tgt_id !== 4'd7 || gnt !== 10'h080) begin n_fail++; $display("FAIL err_grant got id=%0d gnt=%h want 7/080", tgt_id, gnt); end
    @(negedge clk);
    req = '0;
    tgt_r_valid = 1'b1;
    tgt_r_id = 4'd2;
    #1;
    n_checks++; if (r_valid !== 10'h080 || err !== 1'b0) begin n_fail++; $display("FAIL err_mismatch_route got %h err=%b want 080/0", r_valid, err); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tgt_r_valid = 1'b0;
      #1;
      n_checks++; if (err !== 1'b1 || outstanding !== 3'd0) begin n_fail++; $display("FAIL err_sticky c=%0d got err=%b cnt=%0d want 1/0", c, err, outstanding); end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_final_clear got %b want 0", err); end
  endtask
  initial begin
    for (int i = 0; i < 10; i++) begin
      add[i] = 32'hA000_0000 + 32'(i * 16);
      wdata[i] = 32'h5000_0000 + 32'(i * 3);
      be[i] = 4'(i);
      wen[i] = i[0];
    end
    test_reset();
    test_fairness();
    test_lock();
    test_full();
    test_back_to_back();
    test_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
